sdram_arbiter: RTL

Two-port arbiter that shares the single SDRAM transaction bus (sdram_stb/we/sel/adr/out/dat/ack) between the processor port (A) and a secondary bus master (B), for example a disk DMA or video fetch engine. It sits between the kernel-side masters and the board-level SDRAM glue. It registers the winning request, drives one downstream transaction at a time, and returns data and a classic hold-until-release acknowledge to the winner.

---
 rtl/sdram_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/sdram_arbiter.sv
// Two-port arbiter sharing one SDRAM transaction bus between processor port A
// and a secondary master B; one registered downstream transaction at a time.
module sdram_arbiter #(
  parameter bit PRIO = 1'b0,
  parameter int AW   = 21
) (
  input  logic          clk_p,
  input  logic          reset,

  input  logic          a_stb,
  input  logic          a_we,
  input  logic [1:0]    a_sel,
  input  logic [AW:1]   a_adr,
  input  logic [15:0]   a_out,
  output logic [15:0]   a_dat,
  output logic          a_ack,

  input  logic          b_stb,
  input  logic          b_we,
  input  logic [1:0]    b_sel,
  input  logic [AW:1]   b_adr,
  input  logic [15:0]   b_out,
  output logic [15:0]   b_dat,
  output logic          b_ack,

  input  logic          sdram_ready,
  output logic          sdram_stb,
  output logic          sdram_we,
  output logic [1:0]    sdram_sel,
  output logic [AW:1]   sdram_adr,
  output logic [15:0]   sdram_out,
  input  logic [15:0]   sdram_dat,
  input  logic          sdram_ack,

  output logic          grant
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RELEASE} state_t;

  state_t state, state_nxt;
  logic   win_b;
  logic   win_stb;
  logic   do_grant;
  logic   do_done;
  logic   do_exit;

  // In round-robin mode a tie goes to the port that did not own the bus last.
  always_comb begin
    win_b     = b_stb && (!a_stb || (!PRIO && !grant));
    win_stb   = grant ? b_stb : a_stb;
    state_nxt = state;
    do_grant  = 1'b0;
    do_done   = 1'b0;
    do_exit   = 1'b0;
    case (state)
      S_IDLE: begin
        if (sdram_ready && (a_stb || b_stb)) begin
          do_grant  = 1'b1;
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (sdram_ack) begin
          do_done   = 1'b1;
          state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!win_stb && !sdram_ack) begin
          do_exit   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_p) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Downstream request fields load only on a grant edge and stay put until the next one.
  always_ff @(posedge clk_p) begin
    if (reset) begin
      sdram_stb <= 1'b0;
      sdram_we  <= 1'b0;
      sdram_sel <= '0;
      sdram_adr <= '0;
      sdram_out <= '0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_dat     <= '0;
      b_dat     <= '0;
      grant     <= 1'b0;
    end else begin
      if (do_grant) begin
        grant     <= win_b;
        sdram_stb <= 1'b1;
        sdram_we  <= win_b ? b_we  : a_we;
        sdram_sel <= win_b ? b_sel : a_sel;
        sdram_adr <= win_b ? b_adr : a_adr;
        sdram_out <= win_b ? b_out : a_out;
      end
      // A winner that has already let go of stb gets neither data nor ack.
      if (do_done) begin
        sdram_stb <= 1'b0;
        if (win_stb) begin
          if (grant) begin
            b_ack <= 1'b1;
            if (!sdram_we) b_dat <= sdram_dat;
          end else begin
            a_ack <= 1'b1;
            if (!sdram_we) a_dat <= sdram_dat;
          end
        end
      end
      if (do_exit) begin
        a_ack <= 1'b0;
        b_ack <= 1'b0;
      end
    end
  end

endmodule
